// File: rtl/sead_fault_ctrl.sv
// SEAD fault controller: background register-file scrub, error stall/restart, fatal lock.
// Optional last-error log (err_src/err_addr) is built when SEAD_ERR_LOG_EN is defined.
module sead_fault_ctrl #(
  parameter int SCRUB_INTERVAL = 64,
  parameter int STALL_CYCLES   = 4,
  parameter int MAX_ERRORS     = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_rs1_used,
  input  logic             scrub_err,
  input  logic             pc_err,
  output logic             scrub_rd,
  output logic [4:0]       scrub_addr,
  output logic             stall,
  output logic             restart,
  output logic [CNT_W-1:0] err_count,
  output logic             fatal,
  output logic [1:0]       err_src,
  output logic [4:0]       err_addr
);

  localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL + 1) : 1;
  localparam int SW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;
  localparam logic [IW-1:0] IVL_RELOAD = IW'(SCRUB_INTERVAL - 1);

  typedef enum logic [2:0] {WAIT, SCAN, ALARM, RECOVER, FATAL} state_t;

  state_t        state;
  logic [IW-1:0] ivl_cnt;
  logic [SW-1:0] stall_cnt;
  logic          rf_err;
  logic          pc_hit;
  logic          err_hit;

  // The core always wins port A; scrubbing only proceeds on cycles it leaves free.
  assign scrub_rd = (state == SCAN) & ~core_rs1_used;
  assign rf_err   = scrub_rd & scrub_err;
  assign pc_hit   = pc_err & ((state == WAIT) | (state == SCAN));
  assign err_hit  = rf_err | pc_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT;
      ivl_cnt    <= IVL_RELOAD;
      stall_cnt  <= '0;
      scrub_addr <= 5'd1;
      stall      <= 1'b0;
      restart    <= 1'b0;
      fatal      <= 1'b0;
      err_count  <= '0;
    end else begin
      case (state)
        WAIT, SCAN: begin
          if (err_hit) begin
            state     <= ALARM;
            stall     <= 1'b1;
            stall_cnt <= SW'(STALL_CYCLES - 1);
            if (err_count != {CNT_W{1'b1}})
              err_count <= err_count + 1'b1;
          end else if (state == WAIT) begin
            if (ivl_cnt == '0)
              state <= SCAN;
            else
              ivl_cnt <= ivl_cnt - 1'b1;
          end else if (scrub_rd) begin
            if (scrub_addr == 5'd31) begin
              scrub_addr <= 5'd1;
              state      <= WAIT;
              ivl_cnt    <= IVL_RELOAD;
            end else begin
              scrub_addr <= scrub_addr + 5'd1;
            end
          end
        end
        ALARM: begin
          if (stall_cnt == '0) begin
            state   <= RECOVER;
            restart <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt - 1'b1;
          end
        end
        RECOVER: begin
          restart <= 1'b0;
          if (err_count >= CNT_W'(MAX_ERRORS)) begin
            state <= FATAL;
            fatal <= 1'b1;
          end else begin
            state      <= WAIT;
            stall      <= 1'b0;
            ivl_cnt    <= IVL_RELOAD;
            scrub_addr <= 5'd1;
          end
        end
        FATAL: begin
          stall   <= 1'b1;
          restart <= 1'b0;
          fatal   <= 1'b1;
        end
        default: state <= WAIT;
      endcase
    end
  end

`ifdef SEAD_ERR_LOG_EN
  // A PC-only error keeps the previously logged register index.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_src  <= 2'b00;
      err_addr <= 5'd0;
    end else if (err_hit) begin
      err_src <= {pc_hit, rf_err};
      if (rf_err)
        err_addr <= scrub_addr;
    end
  end
`else
  assign err_src  = 2'b00;
  assign err_addr = 5'd0;
`endif

endmodule

// File: tb/tb_sead_fault_ctrl.sv
// Bench for sead_fault_ctrl: directed vector table, corner sequences, randomized run vs reference model.
module tb_sead_fault_ctrl;
  localparam int SI = 4;
  localparam int SC = 4;
  localparam int ME = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, core_rs1_used, scrub_err, pc_err;
  logic          scrub_rd, stall, restart, fatal;
  logic [4:0]    scrub_addr, err_addr;
  logic [CW-1:0] err_count;
  logic [1:0]    err_src;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sead_fault_ctrl #(.SCRUB_INTERVAL(SI), .STALL_CYCLES(SC), .MAX_ERRORS(ME), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .core_rs1_used(core_rs1_used), .scrub_err(scrub_err),
    .pc_err(pc_err), .scrub_rd(scrub_rd), .scrub_addr(scrub_addr), .stall(stall),
    .restart(restart), .err_count(err_count), .fatal(fatal), .err_src(err_src),
    .err_addr(err_addr)
  );

  typedef struct {
    logic rst, rs1, se, pe;
    int   stall, restart, fatal, rd, addr, cnt, src, eaddr;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic r, a, s, p,
                              input int st, rs, fa, rd, ad, cn, sr, ea);
    vec_t v;
    v.rst = r; v.rs1 = a; v.se = s; v.pe = p;
    v.stall = st; v.restart = rs; v.fatal = fa; v.rd = rd;
    v.addr = ad; v.cnt = cn; v.src = sr; v.eaddr = ea;
    return v;
  endfunction

  // Log outputs read as zero when the capture feature is not built.
  function automatic int lg(input int v);
`ifdef SEAD_ERR_LOG_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic r, a, s, p);
    reset = r; core_rs1_used = a; scrub_err = s; pc_err = p;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic chk_all(input string tag, input int st, rs, fa, rd, ad, cn, sr, ea);
    chk({tag, "_stall"}, stall, st);
    chk({tag, "_restart"}, restart, rs);
    chk({tag, "_fatal"}, fatal, fa);
    chk({tag, "_scrub_rd"}, scrub_rd, rd);
    chk({tag, "_scrub_addr"}, scrub_addr, ad);
    chk({tag, "_err_count"}, err_count, cn);
    chk({tag, "_err_src"}, err_src, lg(sr));
    chk({tag, "_err_addr"}, err_addr, lg(ea));
  endtask

  // One scrub pass after reset; alt makes the core take port A every other cycle.
  task automatic scan_pass(input bit alt);
    int cycles = 0;
    int grants = 0;
    bit done = 0;
    do_reset();
    for (int k = 0; k < SI; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 100 && !done; k++) begin
      drive(1'b0, alt ? (cycles % 2 == 0) : 1'b0, 1'b0, 1'b0);
      cycles++;
      if (scrub_rd) begin
        grants++;
        if (grants == 1 || grants == 31) chk("pass_addr", scrub_addr, grants);
        if (scrub_addr == 5'd31) done = 1;
      end
      tick();
    end
    chk(alt ? "pass_len_alt" : "pass_len", cycles, alt ? 62 : 31);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pass_back_wait_rd", scrub_rd, 0);
    chk("pass_wrap_addr", scrub_addr, 1);
    chk("pass_no_stall", stall, 0);
  endtask

  // Reference model state
  bit m_fatal, m_scan;
  int m_err_t, m_wait, m_addr, m_cnt, m_src, m_eaddr;

  task automatic m_init();
    m_fatal = 0; m_scan = 0; m_err_t = -1; m_wait = SI - 1;
    m_addr = 1; m_cnt = 0; m_src = 0; m_eaddr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(0,0,0,0, 0,0,0,0,1,0,0,0);
    tbl[1]  = mk(0,0,0,0, 0,0,0,0,1,0,0,0);
    tbl[2]  = mk(0,0,0,0, 0,0,0,0,1,0,0,0);
    tbl[3]  = mk(0,0,0,0, 0,0,0,0,1,0,0,0);
    tbl[4]  = mk(0,0,0,0, 0,0,0,1,1,0,0,0);
    tbl[5]  = mk(0,0,0,0, 0,0,0,1,2,0,0,0);
    tbl[6]  = mk(0,1,0,0, 0,0,0,0,3,0,0,0);
    tbl[7]  = mk(0,0,1,0, 0,0,0,1,3,0,0,0);
    tbl[8]  = mk(0,0,0,1, 1,0,0,0,3,1,1,3);
    tbl[9]  = mk(0,0,1,0, 1,0,0,0,3,1,1,3);
    tbl[10] = mk(0,0,0,0, 1,0,0,0,3,1,1,3);
    tbl[11] = mk(0,0,0,0, 1,0,0,0,3,1,1,3);
    tbl[12] = mk(0,0,0,0, 1,1,0,0,3,1,1,3);
    tbl[13] = mk(0,0,0,1, 0,0,0,0,1,1,1,3);
    tbl[14] = mk(0,0,0,0, 1,0,0,0,1,2,2,3);
    tbl[15] = mk(0,0,0,0, 1,0,0,0,1,2,2,3);
    tbl[16] = mk(0,0,0,0, 1,0,0,0,1,2,2,3);
    tbl[17] = mk(0,0,0,0, 1,0,0,0,1,2,2,3);
    tbl[18] = mk(0,0,0,0, 1,1,0,0,1,2,2,3);
    tbl[19] = mk(0,0,0,1, 1,0,1,0,1,2,2,3);
    tbl[20] = mk(0,0,0,0, 1,0,1,0,1,2,2,3);
    tbl[21] = mk(1,0,0,0, 1,0,1,0,1,2,2,3);
    tbl[22] = mk(0,0,0,0, 0,0,0,0,1,0,0,0);

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("reset", 0,0,0,0,1,0,0,0);

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rst, tbl[i].rs1, tbl[i].se, tbl[i].pe);
      chk_all($sformatf("vec%0d", i), tbl[i].stall, tbl[i].restart, tbl[i].fatal,
              tbl[i].rd, tbl[i].addr, tbl[i].cnt, tbl[i].src, tbl[i].eaddr);
      tick();
    end

    // Simultaneous PC and regfile error, then reset in the 2nd ALARM cycle.
    do_reset();
    for (int k = 0; k < SI; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("both_rd", scrub_rd, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("both_stall", stall, 1);
    chk("both_count", err_count, 1);
    chk("both_src", err_src, lg(3));
    chk("both_eaddr", err_addr, lg(1));
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("alarm2_stall", stall, 1);
    tick();
    for (int k = 0; k <= SI; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("rst_alarm_c%0d_stall", k), stall, 0);
      chk($sformatf("rst_alarm_c%0d_restart", k), restart, 0);
      chk($sformatf("rst_alarm_c%0d_rd", k), scrub_rd, (k == SI) ? 1 : 0);
      if (k == 0) begin
        chk("rst_alarm_count", err_count, 0);
        chk("rst_alarm_src", err_src, 0);
      end
      tick();
    end

    scan_pass(1'b0);
    scan_pass(1'b1);

    // Randomized run against the reference model.
    do_reset();
    m_init();
    for (int t = 0; t < 3000; t++) begin
      logic r, a, s, p;
      bit in_err, e_rd, erf;
      int d;
      r = ($urandom % 150) == 0;
      a = $urandom % 2;
      s = ($urandom % 20) == 0;
      p = ($urandom % 60) == 0;
      drive(r, a, s, p);
      in_err = (m_err_t >= 0) && !m_fatal;
      d = t - m_err_t;
      e_rd = m_scan && !m_fatal && !in_err && !a;
      chk_all("rnd", (m_fatal || in_err) ? 1 : 0, (in_err && d == SC + 1) ? 1 : 0,
              m_fatal ? 1 : 0, e_rd ? 1 : 0, m_addr, m_cnt, m_src, m_eaddr);
      if (r) begin
        m_init();
      end else if (m_fatal) begin
      end else if (in_err) begin
        if (d == SC + 1) begin
          if (m_cnt >= ME) m_fatal = 1;
          else begin
            m_err_t = -1; m_wait = SI - 1; m_scan = 0; m_addr = 1;
          end
        end
      end else begin
        erf = e_rd && s;
        if (erf || p) begin
          m_err_t = t;
          if (m_cnt < 255) m_cnt++;
          m_src = (p ? 2 : 0) + (erf ? 1 : 0);
          if (erf) m_eaddr = m_addr;
        end else if (m_scan) begin
          if (e_rd) begin
            if (m_addr == 31) begin
              m_addr = 1; m_scan = 0; m_wait = SI - 1;
            end else m_addr++;
          end
        end else if (m_wait == 0) m_scan = 1;
        else m_wait--;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
